// File: rtl/ysyx_22041412_csr_pkg.sv
// Shared constants for the machine CSR file and the trap sequencer:
// CSR addresses, CSR instruction func3 codes, mstatus bit positions and
// the sequencer state/phase encodings.
package ysyx_22041412_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [2:0] F3_CSRRW = 3'b001;
  localparam logic [2:0] F3_CSRRS = 3'b010;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // One state per CSR access, plus the redirect cycle.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_MEPC,
    ST_W_MCAUSE,
    ST_R_MSTAT,
    ST_W_MSTAT,
    ST_R_TVEC,
    ST_R_EPC,
    ST_DONE
  } trap_state_e;

  // Sub-phase of one CSR access: request outstanding, then one idle gap cycle.
  typedef enum logic [1:0] {
    PH_IDLE,
    PH_ACC,
    PH_GAP
  } csr_phase_e;

endpackage

// File: rtl/ysyx_22041412_trap_ctrl.sv
// Trap sequencer: runs the CSR read/modify/write sequence for trap entry or
// mret over the CSR file's en/ready handshake, then pulses a PC redirect.
module ysyx_22041412_trap_ctrl
  import ysyx_22041412_csr_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int CSR_AW = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trap_valid,
  input  logic              trap_is_mret,
  input  logic [XLEN-1:0]   trap_cause,
  input  logic [XLEN-1:0]   trap_pc,
  output logic              trap_ready,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              csr_en,
  output logic [CSR_AW-1:0] csr_addr,
  output logic [2:0]        csr_func3,
  output logic [XLEN-1:0]   csr_wdata,
  input  logic [XLEN-1:0]   csr_rdata,
  input  logic              csr_ready
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  typedef struct packed {
    logic [CSR_AW-1:0] addr;
    logic [2:0]        func3;
    logic [XLEN-1:0]   wdata;
  } csr_req_t;

  trap_state_e     state_q, state_d;
  csr_phase_e      phase_q, phase_d;
  logic            en_d;
  logic [CSR_AW-1:0] addr_d;
  logic [2:0]      f3_d;
  logic [XLEN-1:0] wdata_d;
  logic            rv_d;
  logic [XLEN-1:0] rpc_d;
  logic            accept;
  csr_req_t        req;

  logic [XLEN-1:0] pc_q, cause_q, rd_q;
  logic            mret_q;

  // mstatus on trap entry: MPIE <- MIE, MIE <- 0, MPP <- M.
  function automatic logic [XLEN-1:0] mstat_enter(input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] r;
    r = ms;
    r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  // mstatus on mret: MIE <- MPIE, MPIE <- 1, MPP stays M (M-only core).
  function automatic logic [XLEN-1:0] mstat_mret(input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] r;
    r = ms;
    r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  // CSR request issued by a given step; reads are CSRRS with zero write data.
  function automatic csr_req_t req_for(input trap_state_e st, input logic [XLEN-1:0] pc,
                                       input logic [XLEN-1:0] cause, input logic [XLEN-1:0] ms,
                                       input logic mret);
    csr_req_t r;
    r.addr  = CSR_AW'(CSR_MSTATUS);
    r.func3 = F3_CSRRS;
    r.wdata = '0;
    case (st)
      ST_W_MEPC: begin
        r.addr  = CSR_AW'(CSR_MEPC);
        r.func3 = F3_CSRRW;
        r.wdata = pc & ALIGN_MASK;
      end
      ST_W_MCAUSE: begin
        r.addr  = CSR_AW'(CSR_MCAUSE);
        r.func3 = F3_CSRRW;
        r.wdata = cause;
      end
      ST_W_MSTAT: begin
        r.func3 = F3_CSRRW;
        r.wdata = mret ? mstat_mret(ms) : mstat_enter(ms);
      end
      ST_R_TVEC: r.addr = CSR_AW'(CSR_MTVEC);
      ST_R_EPC:  r.addr = CSR_AW'(CSR_MEPC);
      default:   r.addr = CSR_AW'(CSR_MSTATUS);
    endcase
    return r;
  endfunction

  // Step order: entry = MEPC, MCAUSE, rd MSTAT, wr MSTAT, rd TVEC; mret joins at rd MSTAT.
  function automatic trap_state_e next_step(input trap_state_e st, input logic mret);
    case (st)
      ST_W_MEPC:   return ST_W_MCAUSE;
      ST_W_MCAUSE: return ST_R_MSTAT;
      ST_R_MSTAT:  return ST_W_MSTAT;
      ST_W_MSTAT:  return mret ? ST_R_EPC : ST_R_TVEC;
      default:     return ST_DONE;
    endcase
  endfunction

  assign trap_ready = (state_q == ST_IDLE);

  // Next-state and next-output logic for the sequencer and its access phase.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    en_d    = csr_en;
    addr_d  = csr_addr;
    f3_d    = csr_func3;
    wdata_d = csr_wdata;
    rv_d    = 1'b0;
    rpc_d   = redirect_pc;
    accept  = 1'b0;
    req     = '0;
    case (state_q)
      ST_IDLE: begin
        if (trap_valid) begin
          accept  = 1'b1;
          state_d = trap_is_mret ? ST_R_MSTAT : ST_W_MEPC;
          req     = req_for(state_d, trap_pc, trap_cause, rd_q, trap_is_mret);
          en_d    = 1'b1;
          phase_d = PH_ACC;
          addr_d  = req.addr;
          f3_d    = req.func3;
          wdata_d = req.wdata;
        end
      end
      ST_W_MEPC, ST_W_MCAUSE, ST_R_MSTAT, ST_W_MSTAT, ST_R_TVEC, ST_R_EPC: begin
        if (phase_q == PH_ACC) begin
          if (csr_ready) begin
            en_d    = 1'b0;
            phase_d = PH_GAP;
          end
        end else begin
          // Gap cycle over: issue the next access or finish with the redirect.
          state_d = next_step(state_q, mret_q);
          if (state_d == ST_DONE) begin
            rv_d    = 1'b1;
            phase_d = PH_IDLE;
            rpc_d   = (state_q == ST_R_TVEC) ? (rd_q & ALIGN_MASK) : rd_q;
          end else begin
            req     = req_for(state_d, pc_q, cause_q, rd_q, mret_q);
            en_d    = 1'b1;
            phase_d = PH_ACC;
            addr_d  = req.addr;
            f3_d    = req.func3;
            wdata_d = req.wdata;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        phase_d = PH_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = PH_IDLE;
        en_d    = 1'b0;
      end
    endcase
  end

  // Control state and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      phase_q        <= PH_IDLE;
      csr_en         <= 1'b0;
      csr_addr       <= '0;
      csr_func3      <= '0;
      csr_wdata      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      csr_en         <= en_d;
      csr_addr       <= addr_d;
      csr_func3      <= f3_d;
      csr_wdata      <= wdata_d;
      redirect_valid <= rv_d;
      redirect_pc    <= rpc_d;
    end
  end

  // Request fields latched at acceptance; CSR read data captured on completion.
  always_ff @(posedge clk) begin
    if (accept) begin
      pc_q    <= trap_pc;
      cause_q <= trap_cause;
      mret_q  <= trap_is_mret;
    end
    if (phase_q == PH_ACC && csr_ready) rd_q <= csr_rdata;
  end

endmodule

// File: tb/tb_ysyx_22041412_trap_ctrl.sv
// Scoreboard bench for the trap sequencer with a small CSR file responder.
module tb_ysyx_22041412_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trap_valid = 1'b0;
  logic        trap_is_mret = 1'b0;
  logic [63:0] trap_cause = '0;
  logic [63:0] trap_pc = '0;
  logic        trap_ready;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        csr_en;
  logic [11:0] csr_addr;
  logic [2:0]  csr_func3;
  logic [63:0] csr_wdata;
  logic [63:0] csr_rdata = '0;
  logic        csr_ready;

  ysyx_22041412_trap_ctrl #(.XLEN(64), .CSR_AW(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .trap_valid(trap_valid), .trap_is_mret(trap_is_mret),
    .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_ready(trap_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .csr_en(csr_en), .csr_addr(csr_addr), .csr_func3(csr_func3),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_ready(csr_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- CSR file model: 0 mstatus, 1 mtvec, 2 mepc, 3 mcause
  logic [63:0] mem [4];
  logic        rdy_q = 1'b0;
  logic        spur = 1'b0;
  logic        ld_req = 1'b0;
  logic [1:0]  ld_idx = '0;
  logic [63:0] ld_val = '0;
  int          acc_cnt = 0;

  function automatic int idx_of(input logic [11:0] a);
    case (a)
      12'h300: return 0;
      12'h305: return 1;
      12'h341: return 2;
      12'h342: return 3;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (ld_req) mem[ld_idx] <= ld_val;
    if (csr_en && !rdy_q) begin
      rdy_q     <= 1'b1;
      csr_rdata <= mem[idx_of(csr_addr)];
      acc_cnt   <= acc_cnt + 1;
      if (csr_func3 == 3'b001) mem[idx_of(csr_addr)] <= csr_wdata;
      else if (csr_func3 == 3'b010) mem[idx_of(csr_addr)] <= mem[idx_of(csr_addr)] | csr_wdata;
    end else begin
      rdy_q <= 1'b0;
    end
  end
  assign csr_ready = rdy_q | spur;

  // ---------------- reference model and scoreboard queues
  typedef struct { logic [11:0] addr; logic [2:0] f3; logic [63:0] wd; } acc_t;
  typedef struct { logic [63:0] pc; int e0; int lat; int base; int n; } redir_t;
  acc_t   exp_acc[$];
  redir_t exp_redir[$];
  int     redir_cnt = 0;

  function automatic logic [63:0] ms_after_trap(input logic [63:0] ms);
    return (ms & ~64'h1888) | 64'h1800 | (ms[3] ? 64'h80 : 64'h0);
  endfunction

  function automatic logic [63:0] ms_after_mret(input logic [63:0] ms);
    return (ms & ~64'h1888) | 64'h1880 | (ms[7] ? 64'h8 : 64'h0);
  endfunction

  task automatic push_acc(input logic [11:0] a, input logic [2:0] f, input logic [63:0] w);
    acc_t e;
    e.addr = a; e.f3 = f; e.wd = w;
    exp_acc.push_back(e);
  endtask

  task automatic push_expect(input logic mret, input logic [63:0] cause, input logic [63:0] pc,
                             input int e0);
    redir_t r;
    r.e0 = e0; r.base = acc_cnt;
    if (!mret) begin
      push_acc(12'h341, 3'b001, pc & ~64'h3);
      push_acc(12'h342, 3'b001, cause);
      push_acc(12'h300, 3'b010, 64'h0);
      push_acc(12'h300, 3'b001, ms_after_trap(mem[0]));
      push_acc(12'h305, 3'b010, 64'h0);
      r.pc = mem[1] & ~64'h3; r.lat = 15; r.n = 5;
    end else begin
      push_acc(12'h300, 3'b010, 64'h0);
      push_acc(12'h300, 3'b001, ms_after_mret(mem[0]));
      push_acc(12'h341, 3'b010, 64'h0);
      r.pc = mem[2]; r.lat = 9; r.n = 3;
    end
    exp_redir.push_back(r);
  endtask

  // ---------------- monitor: pops expectations as the DUT presents accesses/redirects
  logic        en_prev = 1'b0, rv_prev = 1'b0;
  int          en_run = 0;
  logic [11:0] cur_addr = '0;
  logic [2:0]  cur_f3 = '0;
  logic [63:0] cur_wd = '0;

  initial begin : monitor
    acc_t   e;
    redir_t r;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        en_prev = 1'b0; rv_prev = 1'b0; en_run = 0;
      end else begin
        if (csr_en) begin
          if (!en_prev) begin
            chk("csr_access_expected", 64'(exp_acc.size() != 0), 64'd1);
            if (exp_acc.size() != 0) begin
              e = exp_acc.pop_front();
              chk("csr_addr", 64'(csr_addr), 64'(e.addr));
              chk("csr_func3", 64'(csr_func3), 64'(e.f3));
              chk("csr_wdata", csr_wdata, e.wd);
            end
            cur_addr = csr_addr; cur_f3 = csr_func3; cur_wd = csr_wdata;
            en_run = 1;
          end else begin
            en_run++;
            chk("csr_req_stable", 64'(csr_addr == cur_addr && csr_func3 == cur_f3 && csr_wdata == cur_wd), 64'd1);
          end
        end else if (en_prev) begin
          chk("csr_en_width", 64'(en_run), 64'd2);
        end
        if (redirect_valid) begin
          redir_cnt++;
          chk("redirect_single_cycle", 64'(rv_prev), 64'd0);
          chk("redirect_expected", 64'(exp_redir.size() != 0), 64'd1);
          if (exp_redir.size() != 0) begin
            r = exp_redir.pop_front();
            chk("redirect_pc", redirect_pc, r.pc);
            chk("redirect_latency", 64'(cyc - r.e0), 64'(r.lat));
            chk("csr_access_count", 64'(acc_cnt - r.base), 64'(r.n));
            chk("accesses_left_at_redirect", 64'(exp_acc.size()), 64'd0);
          end
        end
        en_prev = csr_en;
        rv_prev = redirect_valid;
      end
    end
  end

  // ---------------- stimulus helpers
  task automatic set_csr(input logic [1:0] i, input logic [63:0] v);
    @(negedge clk);
    ld_req = 1'b1; ld_idx = i; ld_val = v;
    @(negedge clk);
    ld_req = 1'b0;
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    while (!trap_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_within_bound", 64'(trap_ready), 64'd1);
  endtask

  task automatic issue(input logic mret, input logic [63:0] cause, input logic [63:0] pc);
    @(negedge clk);
    trap_valid = 1'b1; trap_is_mret = mret; trap_cause = cause; trap_pc = pc;
    wait_accept();
    push_expect(mret, cause, pc, cyc + 1);
    @(negedge clk);
    trap_valid   = 1'b0;
    trap_is_mret = 1'($urandom);
    trap_cause   = {$urandom, $urandom};
    trap_pc      = {$urandom, $urandom};
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_redir.size() != 0 || !trap_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("sequence_done_within_bound", 64'(exp_redir.size() == 0 && trap_ready), 64'd1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main stimulus
  initial begin : stim
    int n, base;
    logic [63:0] pc0, wd0;
    logic [11:0] addr0;

    #12;
    chk("reset_csr_en", 64'(csr_en), 64'd0);
    chk("reset_csr_addr", 64'(csr_addr), 64'd0);
    chk("reset_csr_func3", 64'(csr_func3), 64'd0);
    chk("reset_csr_wdata", csr_wdata, 64'd0);
    chk("reset_redirect_valid", 64'(redirect_valid), 64'd0);
    chk("reset_redirect_pc", redirect_pc, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(trap_ready), 64'd1);

    // Directed trap entry: mstatus 0x8 -> 0x1880, redirect to aligned mtvec.
    set_csr(0, 64'h8); set_csr(1, 64'h8000_0201); set_csr(2, 64'h0); set_csr(3, 64'h0);
    issue(1'b0, 64'd11, 64'h8000_0104);
    wait_idle();
    chk("mepc_after_trap", mem[2], 64'h8000_0104);
    chk("mcause_after_trap", mem[3], 64'd11);
    chk("mstatus_after_trap", mem[0], 64'h1880);

    // Directed mret: mstatus 0x1880 -> 0x1888, redirect to mepc.
    set_csr(2, 64'h8000_0108);
    issue(1'b1, 64'd0, 64'd0);
    wait_idle();
    chk("mstatus_after_mret", mem[0], 64'h1888);

    // Busy: request held with changed pc while a trap entry runs.
    set_csr(0, 64'h8); set_csr(1, 64'h8000_0400);
    @(negedge clk);
    trap_valid = 1'b1; trap_is_mret = 1'b0; trap_cause = 64'd11; trap_pc = 64'h8000_0110;
    wait_accept();
    push_expect(1'b0, 64'd11, 64'h8000_0110, cyc + 1);
    base = redir_cnt;
    @(negedge clk);
    trap_pc = 64'hDEAD; trap_cause = 64'd7;
    n = 0;
    while (!trap_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("busy_cycles_before_reaccept", 64'(n), 64'd16);
    chk("redirect_before_reaccept", 64'(redir_cnt - base), 64'd1);
    chk("mepc_original_pc", mem[2], 64'h8000_0110);
    push_expect(1'b0, 64'd7, 64'hDEAD, cyc + 1);
    @(negedge clk);
    trap_valid = 1'b0;
    wait_idle();
    chk("mepc_second_pc", mem[2], 64'hDEAC);

    // Reset during the mstatus write of an mret.
    set_csr(0, 64'h1880); set_csr(2, 64'h8000_0108);
    issue(1'b1, 64'd0, 64'd0);
    n = 0;
    while (!(csr_en && csr_addr == 12'h300 && csr_func3 == 3'b001) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reached_w_mstat", 64'(csr_en && csr_addr == 12'h300 && csr_func3 == 3'b001), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_csr_en", 64'(csr_en), 64'd0);
    chk("async_reset_redirect", 64'(redirect_valid), 64'd0);
    exp_acc.delete();
    exp_redir.delete();
    base = redir_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_midop_reset", 64'(trap_ready), 64'd1);
    repeat (20) @(negedge clk);
    chk("no_redirect_after_reset", 64'(redir_cnt - base), 64'd0);

    // Spurious csr_ready pulses while idle.
    pc0 = redirect_pc; addr0 = csr_addr; wd0 = csr_wdata;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      spur = 1'b1;
      @(negedge clk);
      spur = 1'b0;
      chk("spurious_ready_idle", 64'(trap_ready), 64'd1);
      chk("spurious_csr_en", 64'(csr_en), 64'd0);
      chk("spurious_outputs_held",
          64'(redirect_pc == pc0 && csr_addr == addr0 && csr_wdata == wd0 && !redirect_valid), 64'd1);
    end

    // Randomized traffic, some back-to-back.
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        wait_idle();
        set_csr(0, {$urandom, $urandom});
        set_csr(1, {$urandom, $urandom});
        set_csr(2, {$urandom, $urandom});
      end
      issue(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
    end
    wait_idle();
    chk("no_pending_accesses", 64'(exp_acc.size()), 64'd0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
